seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
- Receiving end of the multiplexed 8-digit seven-segment interface: samples the anode/cathode lines the display path drives and rebuilds the eight 4-bit digit values plus the blinking/pointer position from the decimal point.
- Used on-chip as a self-check monitor of the display path and as a capture block for a second display or a logic-analyser port.
- Single clock domain (50 MHz system clock); anode/cathode inputs are synchronous to it.

Parameters:
SETTLE_CYCLES, 16, consecutive cycles an anode slot and its cathode pattern must be unchanged before the slot is captured (minimum 2)
TIMEOUT_CYCLES, 100000, cycles without any capture before scan loss is flagged (2 ms at 50 MHz; one full frame at a 10 kHz refresh is 800 us)

Ports:
clk_i  input  1  system clock, 50 MHz
rst_i  input  1  synchronous, active-high reset
anode_i  input  8  digit enables, active-low; exactly one bit low = valid slot k (bit index)
cathode_i  input  8  segments, active-low; bit0=a, bit1=b, … bit6=g, bit7=dp
digits_o  output  32  digit k at [4k+3:4k]
digit_err_o  output  8  bit k=1: slot k glyph was not a legal hex glyph (digit value forced 0)
ptr_o  output  3  slot whose dp was lit
ptr_valid_o  output  1  exactly one slot in the frame had dp lit
frame_valid_o  output  1  one-cycle pulse: outputs just updated with a complete frame
scan_lost_o  output  1  no capture for TIMEOUT_CYCLES

Behaviour:
- Reset (synchronous, rst_i high at a clk_i edge): all outputs 0; slot mask, settle counter, timeout counter and staging registers cleared. Reset mid-frame discards the partial frame.
- Slot validity: anode_i with exactly one 0 bit is a valid slot. All-ones (blanking) or multiple 0 bits is invalid: settle counter cleared, no capture.
- Settle counter:
  - Increments each cycle while anode_i and cathode_i equal their previous-cycle values and the slot is valid; otherwise it reloads to 0.
  - Capture happens in the cycle the counter reaches SETTLE_CYCLES-1.
  - Exactly one capture per dwell: no recapture until anode_i or cathode_i changes.
- Glyph decode: lit segments of ~cathode_i[6:0] must match one of:
  - 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc
  - 8=abcdefg, 9=abcdfg, A=abcefg, b=cdefg, C=adef, d=bcdeg, E=adefg, F=aefg
  - Any other pattern: staged value 0, staged error bit set.
- Capture: writes the staged digit, error bit and dp bit for slot k, and sets mask bit k. If slot k repeats before the frame completes, the later capture overwrites the earlier one.
- Frame completion:
  - On the cycle after the mask becomes 8'hFF, digits_o/digit_err_o/ptr_o/ptr_valid_o update atomically, frame_valid_o pulses for 1 cycle, and the mask clears.
  - ptr_o is the index of the single dp-lit slot. If zero or more than one slot has dp lit, ptr_valid_o=0 and ptr_o holds its previous value.
- Timeout:
  - Counter clears on every capture.
  - On reaching TIMEOUT_CYCLES: scan_lost_o=1 and the mask clears (partial frame dropped). The counter saturates there.
  - scan_lost_o returns to 0 on the next capture.
  - Frame outputs keep their last values while lost.
- Capture in the same cycle as the timeout threshold: the capture wins; scan_lost_o stays 0 and the counter clears.
- Outputs are registered. Latency from 8th capture to frame_valid_o: 1 cycle.

Optional Feature:
- SEG_SCAN_DOUBLE_CHECK_EN defined:
  - A completed frame is compared against the previous completed frame (digits, error bits, dp bits).
  - Outputs update and frame_valid_o pulses only when the two match.
  - A mismatch discards the update but keeps the new frame as the comparison reference.
  - After reset or scan loss, the first frame is reference-only and produces no pulse.
- Undefined: every completed frame updates the outputs immediately as described in Behaviour.

Test Plan:
- Reset, then drive anode slots 0..7 for 5000 cycles each with glyphs 1,2,3,4,5,6,7,8 and dp on slot 2 -> one frame_valid_o pulse after the 8th capture; digits_o=32'h87654321, ptr_o=2, ptr_valid_o=1, digit_err_o=0.
- Slot 5 cathode = only segment a lit (8'hFE) -> digit_err_o=8'h20, digits_o[23:20]=0.
- Each slot held for only SETTLE_CYCLES-1 cycles, then changed -> no captures, no pulse; after TIMEOUT_CYCLES, scan_lost_o=1.
- dp lit on slots 1 and 6 -> ptr_valid_o=0, ptr_o unchanged. Next frame with dp on slot 6 only -> ptr_o=6, ptr_valid_o=1.
- Complete 4 slots, assert rst_i for 1 cycle, then complete 8 slots -> exactly one pulse, with data only from the post-reset slots.
- With SEG_SCAN_DOUBLE_CHECK_EN: frames A, B, B -> a single pulse, on the third frame, with outputs = B.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Capture side of a multiplexed 8-digit seven-segment scan: rebuilds digit values and dp pointer.
// Optional SEG_SCAN_DOUBLE_CHECK_EN: only publish a frame that matches the previous completed frame.
module seg_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  anode_i,
  input  logic [7:0]  cathode_i,
  output logic [31:0] digits_o,
  output logic [7:0]  digit_err_o,
  output logic [2:0]  ptr_o,
  output logic        ptr_valid_o,
  output logic        frame_valid_o,
  output logic        scan_lost_o
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_PRE  = SW'(SETTLE_CYCLES - 2);
  localparam logic [TW-1:0] TO_MAX      = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_PRE      = TW'(TIMEOUT_CYCLES - 1);

  logic [7:0]    anode_prev_q, anode_prev_d;
  logic [7:0]    cathode_prev_q, cathode_prev_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [TW-1:0] to_q, to_d;
  logic [7:0]    mask_q, mask_d;
  logic [31:0]   stage_dig_q, stage_dig_d;
  logic [7:0]    stage_err_q, stage_err_d;
  logic [7:0]    stage_dp_q, stage_dp_d;
  logic [31:0]   digits_q, digits_d;
  logic [7:0]    err_q, err_d;
  logic [2:0]    ptr_q, ptr_d;
  logic          ptr_valid_q, ptr_valid_d;
  logic          frame_valid_q, frame_valid_d;
  logic          scan_lost_q, scan_lost_d;
`ifdef SEG_SCAN_DOUBLE_CHECK_EN
  logic [31:0]   ref_dig_q, ref_dig_d;
  logic [7:0]    ref_err_q, ref_err_d;
  logic [7:0]    ref_dp_q, ref_dp_d;
  logic          ref_valid_q, ref_valid_d;
`endif

  logic [7:0] sel;
  logic       slot_valid;
  logic [2:0] slot_idx;
  logic       capture;
  logic       timeout_hit;
  logic       frame_done;
  logic       publish;
  logic [3:0] glyph_val;
  logic       glyph_err;
  logic [3:0] dp_cnt;
  logic [2:0] dp_idx;

  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h3F: r = 5'h00;
      7'h06: r = 5'h01;
      7'h5B: r = 5'h02;
      7'h4F: r = 5'h03;
      7'h66: r = 5'h04;
      7'h6D: r = 5'h05;
      7'h7D: r = 5'h06;
      7'h07: r = 5'h07;
      7'h7F: r = 5'h08;
      7'h6F: r = 5'h09;
      7'h77: r = 5'h0A;
      7'h7C: r = 5'h0B;
      7'h39: r = 5'h0C;
      7'h5E: r = 5'h0D;
      7'h79: r = 5'h0E;
      7'h71: r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  always_comb begin
    sel        = ~anode_i;
    slot_valid = (sel != 8'h00) && ((sel & (sel - 8'h01)) == 8'h00);
    slot_idx   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (sel[i]) slot_idx = 3'(i);
    end
    {glyph_err, glyph_val} = decode_glyph(~cathode_i[6:0]);

    anode_prev_d   = anode_i;
    cathode_prev_d = cathode_i;

    // Counter parks at SETTLE_LAST so a long dwell captures only once.
    settle_d = '0;
    capture  = 1'b0;
    if (slot_valid && (anode_i == anode_prev_q) && (cathode_i == cathode_prev_q)) begin
      settle_d = (settle_q == SETTLE_LAST) ? settle_q : settle_q + 1'b1;
      capture  = (settle_q == SETTLE_PRE);
    end

    timeout_hit = !capture && (to_q == TO_PRE);
    if (capture)             to_d = '0;
    else if (to_q == TO_MAX) to_d = to_q;
    else                     to_d = to_q + 1'b1;

    if (capture)          scan_lost_d = 1'b0;
    else if (timeout_hit) scan_lost_d = 1'b1;
    else                  scan_lost_d = scan_lost_q;

    frame_done  = (mask_q == 8'hFF);
    stage_dig_d = stage_dig_q;
    stage_err_d = stage_err_q;
    stage_dp_d  = stage_dp_q;
    mask_d      = (frame_done || timeout_hit) ? 8'h00 : mask_q;
    if (capture) begin
      stage_dig_d[4*slot_idx +: 4] = glyph_val;
      stage_err_d[slot_idx]        = glyph_err;
      stage_dp_d[slot_idx]         = ~cathode_i[7];
      mask_d[slot_idx]             = 1'b1;
    end

    dp_cnt = '0;
    dp_idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (stage_dp_q[i]) begin
        dp_cnt = dp_cnt + 1'b1;
        dp_idx = 3'(i);
      end
    end

`ifdef SEG_SCAN_DOUBLE_CHECK_EN
    // Every completed frame becomes the new reference, matching or not.
    publish     = frame_done && ref_valid_q && (stage_dig_q == ref_dig_q) &&
                  (stage_err_q == ref_err_q) && (stage_dp_q == ref_dp_q);
    ref_dig_d   = frame_done ? stage_dig_q : ref_dig_q;
    ref_err_d   = frame_done ? stage_err_q : ref_err_q;
    ref_dp_d    = frame_done ? stage_dp_q  : ref_dp_q;
    ref_valid_d = timeout_hit ? 1'b0 : (ref_valid_q | frame_done);
`else
    publish = frame_done;
`endif

    digits_d      = digits_q;
    err_d         = err_q;
    ptr_d         = ptr_q;
    ptr_valid_d   = ptr_valid_q;
    frame_valid_d = 1'b0;
    if (publish) begin
      digits_d      = stage_dig_q;
      err_d         = stage_err_q;
      ptr_valid_d   = (dp_cnt == 4'd1);
      ptr_d         = (dp_cnt == 4'd1) ? dp_idx : ptr_q;
      frame_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      anode_prev_q   <= '1;
      cathode_prev_q <= '1;
      settle_q       <= '0;
      to_q           <= '0;
      mask_q         <= '0;
      stage_dig_q    <= '0;
      stage_err_q    <= '0;
      stage_dp_q     <= '0;
      digits_q       <= '0;
      err_q          <= '0;
      ptr_q          <= '0;
      ptr_valid_q    <= 1'b0;
      frame_valid_q  <= 1'b0;
      scan_lost_q    <= 1'b0;
`ifdef SEG_SCAN_DOUBLE_CHECK_EN
      ref_dig_q      <= '0;
      ref_err_q      <= '0;
      ref_dp_q       <= '0;
      ref_valid_q    <= 1'b0;
`endif
    end else begin
      anode_prev_q   <= anode_prev_d;
      cathode_prev_q <= cathode_prev_d;
      settle_q       <= settle_d;
      to_q           <= to_d;
      mask_q         <= mask_d;
      stage_dig_q    <= stage_dig_d;
      stage_err_q    <= stage_err_d;
      stage_dp_q     <= stage_dp_d;
      digits_q       <= digits_d;
      err_q          <= err_d;
      ptr_q          <= ptr_d;
      ptr_valid_q    <= ptr_valid_d;
      frame_valid_q  <= frame_valid_d;
      scan_lost_q    <= scan_lost_d;
`ifdef SEG_SCAN_DOUBLE_CHECK_EN
      ref_dig_q      <= ref_dig_d;
      ref_err_q      <= ref_err_d;
      ref_dp_q       <= ref_dp_d;
      ref_valid_q    <= ref_valid_d;
`endif
    end
  end

  assign digits_o      = digits_q;
  assign digit_err_o   = err_q;
  assign ptr_o         = ptr_q;
  assign ptr_valid_o   = ptr_valid_q;
  assign frame_valid_o = frame_valid_q;
  assign scan_lost_o   = scan_lost_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with shortened timeout; honours SEG_SCAN_DOUBLE_CHECK_EN.
module tb_seg_scan_decoder;
  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 2000;
  localparam int DWELL   = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  anode = 8'hFF;
  logic [7:0]  cathode = 8'hFF;
  logic [31:0] digits_o;
  logic [7:0]  digit_err_o;
  logic [2:0]  ptr_o;
  logic        ptr_valid_o;
  logic        frame_valid_o;
  logic        scan_lost_o;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int p0;

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_valid_o === 1'b1) pulses++;

  seg_scan_decoder #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst), .anode_i(anode), .cathode_i(cathode),
    .digits_o(digits_o), .digit_err_o(digit_err_o), .ptr_o(ptr_o),
    .ptr_valid_o(ptr_valid_o), .frame_valid_o(frame_valid_o), .scan_lost_o(scan_lost_o)
  );

  function automatic logic [7:0] glyph_cath(input logic [3:0] v, input logic dp);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
      4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
      4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
      4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
    endcase
    return {~dp, ~s};
  endfunction

  task automatic drive_slot(input int k, input logic [7:0] cath, input int n);
    @(negedge clk);
    anode = ~(8'h01 << k);
    cathode = cath;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic blank(input int n);
    @(negedge clk);
    anode = 8'hFF;
    cathode = 8'hFF;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] digs, input logic [7:0] dp);
    for (int k = 0; k < 8; k++) drive_slot(k, glyph_cath(digs[4*k +: 4], dp[k]), DWELL);
    blank(8);
  endtask

  task automatic test_reset;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (digits_o !== 32'h0) begin bad++; $display("FAIL reset_digits got=%h exp=0", digits_o); end
    total++; if (digit_err_o !== 8'h0) begin bad++; $display("FAIL reset_err got=%h exp=0", digit_err_o); end
    total++; if (ptr_o !== 3'd0) begin bad++; $display("FAIL reset_ptr got=%0d exp=0", ptr_o); end
    total++; if (ptr_valid_o !== 1'b0) begin bad++; $display("FAIL reset_ptr_valid got=%b exp=0", ptr_valid_o); end
    total++; if (frame_valid_o !== 1'b0) begin bad++; $display("FAIL reset_frame_valid got=%b exp=0", frame_valid_o); end
    total++; if (scan_lost_o !== 1'b0) begin bad++; $display("FAIL reset_scan_lost got=%b exp=0", scan_lost_o); end
  endtask

  task automatic test_basic_frame;
    p0 = pulses;
    send_frame(32'h87654321, 8'h04);
    total++; if (pulses - p0 !== 1) begin bad++; $display("FAIL basic_pulses got=%0d exp=1", pulses - p0); end
    total++; if (digits_o !== 32'h87654321) begin bad++; $display("FAIL basic_digits got=%h exp=87654321", digits_o); end
    total++; if (ptr_o !== 3'd2) begin bad++; $display("FAIL basic_ptr got=%0d exp=2", ptr_o); end
    total++; if (ptr_valid_o !== 1'b1) begin bad++; $display("FAIL basic_ptr_valid got=%b exp=1", ptr_valid_o); end
    total++; if (digit_err_o !== 8'h00) begin bad++; $display("FAIL basic_err got=%h exp=00", digit_err_o); end
    total++; if (scan_lost_o !== 1'b0) begin bad++; $display("FAIL basic_scan_lost got=%b exp=0", scan_lost_o); end
  endtask

  task automatic test_bad_glyph;
    logic [31:0] d;
    d = 32'h87654321;
    p0 = pulses;
    for (int k = 0; k < 8; k++)
      drive_slot(k, (k == 5) ? 8'hFE : glyph_cath(d[4*k +: 4], k == 2), DWELL);
    blank(8);
    total++; if (pulses - p0 !== 1) begin bad++; $display("FAIL glyph_pulses got=%0d exp=1", pulses - p0); end
    total++; if (digit_err_o !== 8'h20) begin bad++; $display("FAIL glyph_err got=%h exp=20", digit_err_o); end
    total++; if (digits_o !== 32'h87054321) begin bad++; $display("FAIL glyph_digits got=%h exp=87054321", digits_o); end
  endtask

  task automatic test_dp_multi;
    send_frame(32'h87654321, 8'h42);
    total++; if (ptr_valid_o !== 1'b0) begin bad++; $display("FAIL dp2_ptr_valid got=%b exp=0", ptr_valid_o); end
    total++; if (ptr_o !== 3'd2) begin bad++; $display("FAIL dp2_ptr_hold got=%0d exp=2", ptr_o); end
    total++; if (digit_err_o !== 8'h00) begin bad++; $display("FAIL dp2_err got=%h exp=00", digit_err_o); end
    send_frame(32'h87654321, 8'h40);
    total++; if (ptr_valid_o !== 1'b1) begin bad++; $display("FAIL dp6_ptr_valid got=%b exp=1", ptr_valid_o); end
    total++; if (ptr_o !== 3'd6) begin bad++; $display("FAIL dp6_ptr got=%0d exp=6", ptr_o); end
  endtask

  task automatic test_short_dwell;
    p0 = pulses;
    total++; if (scan_lost_o !== 1'b0) begin bad++; $display("FAIL short_pre_lost got=%b exp=0", scan_lost_o); end
    for (int i = 0; i < 150; i++) drive_slot(i % 8, glyph_cath(4'(i % 8), 1'b0), SETTLE - 1);
    total++; if (pulses - p0 !== 0) begin bad++; $display("FAIL short_pulses got=%0d exp=0", pulses - p0); end
    total++; if (scan_lost_o !== 1'b1) begin bad++; $display("FAIL short_lost got=%b exp=1", scan_lost_o); end
    total++; if (digits_o !== 32'h87654321) begin bad++; $display("FAIL short_digits_hold got=%h exp=87654321", digits_o); end
    total++; if (ptr_o !== 3'd6) begin bad++; $display("FAIL short_ptr_hold got=%0d exp=6", ptr_o); end
    drive_slot(0, glyph_cath(4'h1, 1'b0), DWELL);
    blank(4);
    total++; if (scan_lost_o !== 1'b0) begin bad++; $display("FAIL lost_recover got=%b exp=0", scan_lost_o); end
  endtask

  task automatic test_reset_mid_frame;
    for (int k = 0; k < 4; k++) drive_slot(k, glyph_cath(4'hE, 1'b1), DWELL);
    @(negedge clk); anode = 8'hFF; cathode = 8'hFF; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    total++; if (digits_o !== 32'h0) begin bad++; $display("FAIL midrst_digits got=%h exp=0", digits_o); end
    p0 = pulses;
    drive_slot(4, glyph_cath(4'hC, 1'b0), DWELL);
    drive_slot(5, glyph_cath(4'hD, 1'b0), DWELL);
    drive_slot(6, glyph_cath(4'hE, 1'b0), DWELL);
    drive_slot(7, glyph_cath(4'hF, 1'b1), DWELL);
    blank(8);
    total++; if (pulses - p0 !== 0) begin bad++; $display("FAIL midrst_partial got=%0d exp=0", pulses - p0); end
    drive_slot(0, glyph_cath(4'h0, 1'b0), DWELL);
    drive_slot(1, glyph_cath(4'h9, 1'b0), DWELL);
    drive_slot(2, glyph_cath(4'hA, 1'b0), DWELL);
    drive_slot(3, glyph_cath(4'hB, 1'b0), DWELL);
    blank(8);
    total++; if (pulses - p0 !== 1) begin bad++; $display("FAIL midrst_pulses got=%0d exp=1", pulses - p0); end
    total++; if (digits_o !== 32'hFEDCBA90) begin bad++; $display("FAIL midrst_digits2 got=%h exp=FEDCBA90", digits_o); end
    total++; if (ptr_o !== 3'd7) begin bad++; $display("FAIL midrst_ptr got=%0d exp=7", ptr_o); end
  endtask

  task automatic test_double_check;
    p0 = pulses;
    send_frame(32'h87654321, 8'h04);
    total++; if (pulses - p0 !== 0) begin bad++; $display("FAIL dbl_first got=%0d exp=0", pulses - p0); end
    send_frame(32'h12345678, 8'h20);
    total++; if (pulses - p0 !== 0) begin bad++; $display("FAIL dbl_second got=%0d exp=0", pulses - p0); end
    total++; if (digits_o !== 32'h0) begin bad++; $display("FAIL dbl_digits_held got=%h exp=0", digits_o); end
    send_frame(32'h12345678, 8'h20);
    total++; if (pulses - p0 !== 1) begin bad++; $display("FAIL dbl_third got=%0d exp=1", pulses - p0); end
    total++; if (digits_o !== 32'h12345678) begin bad++; $display("FAIL dbl_digits got=%h exp=12345678", digits_o); end
    total++; if (ptr_o !== 3'd5) begin bad++; $display("FAIL dbl_ptr got=%0d exp=5", ptr_o); end
    total++; if (ptr_valid_o !== 1'b1) begin bad++; $display("FAIL dbl_ptr_valid got=%b exp=1", ptr_valid_o); end
  endtask

  initial begin
    test_reset;
`ifdef SEG_SCAN_DOUBLE_CHECK_EN
    test_double_check;
`else
    test_basic_frame;
    test_bad_glyph;
    test_dp_multi;
    test_short_dwell;
    test_reset_mid_frame;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
